fn_scan_ctrl: RTL and testbench

//  Sequencer for a 4-input combinational Boolean function block (inputs w,x,y,z; output out).
//  On start it sweeps all 2^N_IN input vectors, waits a settle time, and samples the function output.
//  It records the full truth table and compares it against an expected minterm mask.

---
 rtl/fn_scan_pkg.sv | 14 +
 rtl/fn_scan_if.sv | 32 +++
 rtl/fn_scan_rec.sv | 89 ++++++++
 rtl/fn_scan_ctrl.sv | 104 ++++++++++
 tb/tb_fn_scan_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fn_scan_pkg.sv
// Shared constants for the truth-table scan controller: state encoding, default
// input count and the golden minterm mask of the board function.
package fn_scan_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int N_IN_DEF = 4;

  localparam logic [15:0] FN_GOLDEN_MASK = 16'hF0D9;

endpackage

// File: rtl/fn_scan_if.sv
// Bundle between the scan controller and its host/function block.
// master = stimulus/host side, slave = fn_scan_ctrl.
interface fn_scan_if
  import fn_scan_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);
  localparam int TW = 1 << N_IN;

  logic            start;
  logic [TW-1:0]   expect_mask;
  logic            f_in;
  logic [N_IN-1:0] vec_o;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_o;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_idx;
  logic            first_err_vld;

  modport master (
    output start, expect_mask, f_in,
    input  vec_o, busy, done, table_o, pass, err_cnt, first_err_idx, first_err_vld
  );

  modport slave (
    input  start, expect_mask, f_in,
    output vec_o, busy, done, table_o, pass, err_cnt, first_err_idx, first_err_vld
  );

endinterface

// File: rtl/fn_scan_rec.sv
// Result recorder: captures the truth table, compares each sample against the
// mask latched at start, and keeps the mismatch count and lowest failing index.
module fn_scan_rec
  import fn_scan_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  localparam int TW = 1 << N_IN,
  localparam int ERR_W = N_IN + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            smp,
  input  logic            fin,
  input  logic [N_IN-1:0] idx,
  input  logic            f_in,
  input  logic [TW-1:0]   mask_in,
  output logic            mismatch,
  output logic [TW-1:0]   table_o,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_vld,
  output logic            pass
);

  logic [TW-1:0]   mask_q, mask_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fidx_q, fidx_d;
  logic            fvld_q, fvld_d;
  logic            pass_q, pass_d;

  assign mask_d   = clr ? mask_in : mask_q;
  assign mismatch = smp && (f_in != mask_q[idx]);

  always_comb begin
    table_d = table_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    pass_d  = pass_q;
    if (clr) begin
      table_d = '0;
      err_d   = '0;
      fidx_d  = '0;
      fvld_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (smp) begin
      table_d[idx] = f_in;
      if (mismatch) begin
        err_d = err_q + ERR_W'(1);
        if (!fvld_q) begin
          fidx_d = idx;
          fvld_d = 1'b1;
        end
      end
      // pass must reflect the final sample, so it is taken from err_d
      if (fin) pass_d = (err_d == '0);
    end
  end

  // The expected mask is plain data and needs no reset
  always_ff @(posedge clk) begin
    mask_q <= mask_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_q <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      table_q <= table_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
      pass_q  <= pass_d;
    end
  end

  assign table_o       = table_q;
  assign err_cnt       = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;
  assign pass          = pass_q;

endmodule

// File: rtl/fn_scan_ctrl.sv
// Sweeps every input vector of a combinational function block, settles, samples
// and records the truth table. Optional `FN_SCAN_STOP_ON_FAIL_EN ends at first mismatch.
module fn_scan_ctrl
  import fn_scan_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fn_scan_if.slave   bus
);

  localparam int TW = 1 << N_IN;
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

`ifdef FN_SCAN_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            clr, smp, fin, mismatch;

  assign fin = (state_q == S_SAMPLE) &&
               ((idx_q == IDX_LAST) || (STOP_ON_FAIL && mismatch));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    smp     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        smp = 1'b1;
        if (fin) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load the vector on entry to SETTLE so it is stable for the whole settle window
  assign vec_d = (state_d == S_SETTLE) ? idx_d : vec_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.vec_o = vec_q;
  assign bus.busy  = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.done  = (state_q == S_DONE);

  fn_scan_rec #(.N_IN(N_IN)) u_rec (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .smp           (smp),
    .fin           (fin),
    .idx           (idx_q),
    .f_in          (bus.f_in),
    .mask_in       (bus.expect_mask),
    .mismatch      (mismatch),
    .table_o       (bus.table_o),
    .err_cnt       (bus.err_cnt),
    .first_err_idx (bus.first_err_idx),
    .first_err_vld (bus.first_err_vld),
    .pass          (bus.pass)
  );

endmodule

// File: tb/tb_fn_scan_ctrl.sv
// Scoreboard bench for fn_scan_ctrl: directed scans push expected results,
// monitors pop and compare on every done pulse.
module tb_fn_scan_ctrl;
  import fn_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fn_scan_if #(.N_IN(4)) bus1 ();
  fn_scan_if #(.N_IN(4)) bus2 ();

  fn_scan_ctrl #(.N_IN(4), .SETTLE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fn_scan_ctrl #(.N_IN(4), .SETTLE_CYC(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic logic fmodel(input logic [3:0] v);
    logic w, x, y, z;
    {w, x, y, z} = v;
    return (x | ~w) & (w | y | ~z) & (x | z | (~x & ~y));
  endfunction

  always_comb bus1.f_in = fmodel(bus1.vec_o);
  always_comb bus2.f_in = fmodel(bus2.vec_o);

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic        fvld;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic exp_t mk(input logic [15:0] t, input logic p, input logic [4:0] e,
                              input logic [3:0] fi, input logic fv, input int l);
    exp_t r;
    r.tbl = t; r.pass = p; r.err = e; r.fidx = fi; r.fvld = fv; r.lat = l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut1
  initial begin
    int   lat = 0;
    logic busy_d = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus1.busy === 1'b1 && !busy_d) lat = 1; else lat++;
      busy_d = bus1.busy;
      if (bus1.done === 1'b1) begin
        if (q1.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL dut1_unexpected_done: got done=1 expected no done");
        end else begin
          e = q1.pop_front();
          chk("dut1_table", 32'(bus1.table_o), 32'(e.tbl));
          chk("dut1_pass", 32'(bus1.pass), 32'(e.pass));
          chk("dut1_err_cnt", 32'(bus1.err_cnt), 32'(e.err));
          chk("dut1_first_err_idx", 32'(bus1.first_err_idx), 32'(e.fidx));
          chk("dut1_first_err_vld", 32'(bus1.first_err_vld), 32'(e.fvld));
          chk("dut1_latency", lat, e.lat);
        end
      end
    end
  end

  // Monitor for dut2, also checks that each vector is held SETTLE_CYC+1 = 4 cycles
  initial begin
    int         lat = 0;
    int         run = 0;
    bit         seen = 1'b0;
    logic       busy_d = 1'b0;
    logic [3:0] vprev = 4'd0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (bus2.busy === 1'b1 && !busy_d) lat = 1; else lat++;
      busy_d = bus2.busy;
      if (bus2.vec_o !== vprev) begin
        if (seen && bus2.busy === 1'b1) chk("dut2_vec_hold_len", run, 4);
        seen = 1'b1;
        run = 1;
        vprev = bus2.vec_o;
      end else begin
        run++;
      end
      if (bus2.done === 1'b1) begin
        if (q2.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL dut2_unexpected_done: got done=1 expected no done");
        end else begin
          e = q2.pop_front();
          chk("dut2_table", 32'(bus2.table_o), 32'(e.tbl));
          chk("dut2_pass", 32'(bus2.pass), 32'(e.pass));
          chk("dut2_err_cnt", 32'(bus2.err_cnt), 32'(e.err));
          chk("dut2_latency", lat, e.lat);
        end
      end
    end
  end

  task automatic wait_done(input bit which);
    int k = 0;
    while (((which ? bus2.done : bus1.done) !== 1'b1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
    end
  endtask

  task automatic run1(input logic [15:0] m, input exp_t e);
    q1.push_back(e);
    @(negedge clk);
    bus1.expect_mask = m;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_done(1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_vec_o"}, 32'(bus1.vec_o), 0);
    chk({tag, "_table"}, 32'(bus1.table_o), 0);
    chk({tag, "_err_cnt"}, 32'(bus1.err_cnt), 0);
    chk({tag, "_first_err_idx"}, 32'(bus1.first_err_idx), 0);
    chk({tag, "_flags"}, {28'd0, bus1.busy, bus1.done, bus1.pass, bus1.first_err_vld}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.expect_mask = '0;
    bus2.start = 1'b0; bus2.expect_mask = '0;
    repeat (3) @(negedge clk);
    chk_reset1("reset");
    chk("reset_dut2_flags", {29'd0, bus2.busy, bus2.done, bus2.pass}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden scan
    run1(FN_GOLDEN_MASK, mk(16'hF0D9, 1'b1, 5'd0, 4'd0, 1'b0, 33));
    chk("vec_hold_after_scan", 32'(bus1.vec_o), 32'hF);

`ifdef FN_SCAN_STOP_ON_FAIL_EN
    run1(16'hF0D8, mk(16'h0001, 1'b0, 5'd1, 4'd0, 1'b1, 3));
    run1(16'h0000, mk(16'h0001, 1'b0, 5'd1, 4'd0, 1'b1, 3));
    run1(16'hF4F9, mk(16'h0019, 1'b0, 5'd1, 4'd5, 1'b1, 13));
    run1(16'hFFFF, mk(16'h0001, 1'b0, 5'd1, 4'd1, 1'b1, 5));
`else
    run1(16'hF0D8, mk(16'hF0D9, 1'b0, 5'd1, 4'd0, 1'b1, 33));
    run1(16'h0000, mk(16'hF0D9, 1'b0, 5'd9, 4'd0, 1'b1, 33));
    run1(16'hF4F9, mk(16'hF0D9, 1'b0, 5'd2, 4'd5, 1'b1, 33));
    run1(16'hFFFF, mk(16'hF0D9, 1'b0, 5'd7, 4'd1, 1'b1, 33));
`endif

    // Reset ten cycles into a scan: no done may follow
    @(negedge clk);
    bus1.expect_mask = 16'h0000;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset1("midscan_reset");
    repeat (40) @(negedge clk);
    run1(FN_GOLDEN_MASK, mk(16'hF0D9, 1'b1, 5'd0, 4'd0, 1'b0, 33));

    // Start held through the scan and the done cycle: exactly one scan
    q1.push_back(mk(16'hF0D9, 1'b1, 5'd0, 4'd0, 1'b0, 33));
    @(negedge clk);
    bus1.expect_mask = FN_GOLDEN_MASK;
    bus1.start = 1'b1;
    @(negedge clk);
    wait_done(1'b0);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_requeued_scan_busy", 32'(bus1.busy), 0);
    chk("no_requeued_scan_done", 32'(bus1.done), 0);
    run1(FN_GOLDEN_MASK, mk(16'hF0D9, 1'b1, 5'd0, 4'd0, 1'b0, 33));

    // Longer settle build
    q2.push_back(mk(16'hF0D9, 1'b1, 5'd0, 4'd0, 1'b0, 65));
    @(negedge clk);
    bus2.expect_mask = FN_GOLDEN_MASK;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    wait_done(1'b1);
    repeat (4) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
